led_blink_multi: RTL

Multi-channel, parametrised LED blink sequencer. Each of CH independent channels produces a pulse train of programmable OFF/ON phase lengths, in decisecond-style ticks, repeated a programmable number of times or indefinitely. The block sits between the lock controller FSM and the board LED pins and replaces single-channel blink logic. Each channel has its own start/abort control and a completion pulse.

---
 rtl/led_blink_pkg.sv | 20 ++
 rtl/led_blink_chan.sv | 152 +++++++++++++++
 rtl/led_blink_multi.sv | 54 +++++
 3 files changed

// File: rtl/led_blink_pkg.sv
// Shared types and helpers for the multi-channel LED blink sequencer.
package led_blink_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    typedef enum logic {
        PH_FIRST  = 1'b0,
        PH_SECOND = 1'b1
    } phase_t;

    // Clock cycles per phase tick; the top refuses to elaborate unless this is exact and >= 2.
    function automatic int tick_cycles(input int clkfreq, input int tick_hz);
        return clkfreq / tick_hz;
    endfunction

endpackage

// File: rtl/led_blink_chan.sv
// One blink channel: latches its programme on GO, then walks first/second phases
// on a private tick prescaler until the blink count is reached or ABORT arrives.
module led_blink_chan
    import led_blink_pkg::*;
#(
    parameter int TICK_CYC = 2,
    parameter int DW       = 5,
    parameter int RW       = 3
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          go,
    input  logic          abort,
    input  logic          start_on,
    input  logic [DW-1:0] on_dur,
    input  logic [DW-1:0] off_dur,
    input  logic [RW-1:0] rep,
    output logic          led,
    output logic          busy,
    output logic          done
);

    localparam int            PW         = $clog2(TICK_CYC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYC - 1);

    state_t        state;
    phase_t        phase;
    logic [PW-1:0] presc;
    logic [DW-1:0] tick;
    logic [RW-1:0] blinks;
    logic [DW-1:0] on_q;
    logic [DW-1:0] off_q;
    logic [RW-1:0] rep_q;
    logic          start_on_q;
    logic          led_q;

    logic [DW-1:0] first_dur;
    logic [DW-1:0] second_dur;
    logic [DW-1:0] cur_dur;
    logic [DW-1:0] go_first_dur;
    logic [DW-1:0] go_second_dur;
    logic [RW-1:0] blinks_next;
    logic          all_zero;
    logic          tick_end;
    logic          phase_end;
    logic          last_blink;

    // Phase order follows START_ON; a zero-length phase is never entered, so
    // cur_dur is nonzero whenever a phase is live except in the all-zero run.
    always_comb begin
        first_dur     = start_on_q ? on_q  : off_q;
        second_dur    = start_on_q ? off_q : on_q;
        cur_dur       = (phase == PH_FIRST) ? first_dur : second_dur;
        go_first_dur  = start_on ? on_dur  : off_dur;
        go_second_dur = start_on ? off_dur : on_dur;
        all_zero      = (on_q == '0) && (off_q == '0);
        tick_end      = (presc == PRESC_LAST);
        phase_end     = tick_end && (tick == cur_dur - DW'(1));
        blinks_next   = blinks + RW'(1);
        last_blink    = (rep_q != '0) && (blinks_next == rep_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            phase      <= PH_FIRST;
            presc      <= '0;
            tick       <= '0;
            blinks     <= '0;
            on_q       <= '0;
            off_q      <= '0;
            rep_q      <= '0;
            start_on_q <= 1'b0;
            led_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    led_q <= 1'b0;
                    if (go && !abort) begin
                        state      <= RUN;
                        on_q       <= on_dur;
                        off_q      <= off_dur;
                        rep_q      <= rep;
                        start_on_q <= start_on;
                        presc      <= '0;
                        tick       <= '0;
                        blinks     <= '0;
                        if (go_first_dur != '0) begin
                            phase <= PH_FIRST;
                            led_q <= start_on;
                        end else begin
                            phase <= PH_SECOND;
                            led_q <= !start_on && (go_second_dur != '0);
                        end
                    end
                end

                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        led_q <= 1'b0;
                    end else if (all_zero) begin
                        state <= COMPLETE;
                        led_q <= 1'b0;
                    end else begin
                        if (tick_end) begin
                            presc <= '0;
                            tick  <= phase_end ? '0 : tick + DW'(1);
                        end else begin
                            presc <= presc + PW'(1);
                        end

                        // End of a phase: either move to the second phase or close out a blink.
                        if (phase_end) begin
                            if ((phase == PH_FIRST) && (second_dur != '0)) begin
                                phase <= PH_SECOND;
                                led_q <= !start_on_q;
                            end else begin
                                blinks <= blinks_next;
                                if (last_blink) begin
                                    state <= COMPLETE;
                                    led_q <= 1'b0;
                                end else if (first_dur != '0) begin
                                    phase <= PH_FIRST;
                                    led_q <= start_on_q;
                                end else begin
                                    phase <= PH_SECOND;
                                    led_q <= !start_on_q;
                                end
                            end
                        end
                    end
                end

                COMPLETE: begin
                    state <= IDLE;
                    led_q <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    led_q <= 1'b0;
                end
            endcase
        end
    end

    assign led  = led_q;
    assign busy = (state == RUN);
    assign done = (state == COMPLETE);

endmodule

// File: rtl/led_blink_multi.sv
// CH independent blink channels between the lock controller and the board LEDs;
// the top only slices the packed programme buses and replicates the channel.
module led_blink_multi
    import led_blink_pkg::*;
#(
    parameter int CLKFREQ = 12000000,
    parameter int TICK_HZ = 10,
    parameter int CH      = 4,
    parameter int DW      = 5,
    parameter int RW      = 3
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [CH-1:0]   GO,
    input  logic [CH-1:0]   ABORT,
    input  logic [CH-1:0]   START_ON,
    input  logic [CH*DW-1:0] ON,
    input  logic [CH*DW-1:0] OFF,
    input  logic [CH*RW-1:0] REPEAT,
    output logic [CH-1:0]   LED,
    output logic [CH-1:0]   BUSY,
    output logic [CH-1:0]   DONE
);

    localparam int TICK_CYC = tick_cycles(CLKFREQ, TICK_HZ);

    // A fractional or sub-2 tick would make phase lengths silently wrong.
    generate
        if (((CLKFREQ % TICK_HZ) != 0) || (TICK_CYC < 2)) begin : g_bad_tick
            $error("led_blink_multi: CLKFREQ/TICK_HZ must be an integer >= 2");
        end
    endgenerate

    for (genvar i = 0; i < CH; i++) begin : g_chan
        led_blink_chan #(
            .TICK_CYC(TICK_CYC),
            .DW      (DW),
            .RW      (RW)
        ) u_chan (
            .CLK     (CLK),
            .RST     (RST),
            .go      (GO[i]),
            .abort   (ABORT[i]),
            .start_on(START_ON[i]),
            .on_dur  (ON[i*DW +: DW]),
            .off_dur (OFF[i*DW +: DW]),
            .rep     (REPEAT[i*RW +: RW]),
            .led     (LED[i]),
            .busy    (BUSY[i]),
            .done    (DONE[i])
        );
    end

endmodule
